// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// ------------------
// Write-back scheduler for a dual-write-port register file. Three producers
// (ALU lane 0, ALU lane 1, load/mul-div) hand over completed results through a
// valid/ready handshake. Each producer has its own in-order FIFO. Every cycle
// up to two FIFO heads are scheduled onto the two register-file write ports.
//
// Scheduling rules:
//   - Producers are scanned round-robin, starting at rr_ptr.
//   - When several heads target the same register, only the oldest one is
//     eligible, so the two ports never carry the same address in one cycle.
//     Age is judged from a wrap-aware program-order tag.
//   - A head whose destination is r0 is dropped without using a port.
//
// Parameters:
//   FIFO_DEPTH : entries per producer FIFO (power of two, 2..8)
//   TAG_W      : width of the program-order age tag
//
// Ports:
//   clk                 core clock, rising edge
//   rst                 asynchronous active-low reset
//   req_valid[2:0]      per-producer result valid
//   req_ready[2:0]      per-producer FIFO has room (from registered count only)
//   req_rd[14:0]        destination register, 5 bits per producer
//   req_data[95:0]      result data, 32 bits per producer
//   req_tag[3*TAG_W-1:0] age tag, TAG_W bits per producer
//   we1/wr_addr1/wr_data1  registered write port 1
//   we2/wr_addr2/wr_data2  registered write port 2
//   busy                any FIFO non-empty or any write port active
//   stall_cnt[15:0]     only with WB_STALL_CNT_EN: saturating count of cycles
//                       in which a real (non-r0) head was left waiting
//
// Build option: define WB_STALL_CNT_EN to add the stall_cnt output.

module regfile_wb_arbiter #(
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [2:0]           req_valid,
  output logic [2:0]           req_ready,
  input  logic [14:0]          req_rd,
  input  logic [95:0]          req_data,
  input  logic [3*TAG_W-1:0]   req_tag,
  output logic                 we1,
  output logic [4:0]           wr_addr1,
  output logic [31:0]          wr_data1,
  output logic                 we2,
  output logic [4:0]           wr_addr2,
  output logic [31:0]          wr_data2,
  output logic                 busy
`ifdef WB_STALL_CNT_EN
  ,
  output logic [15:0]          stall_cnt
`endif
);

  localparam int NP    = 3;
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  // Half of the tag space: a forward distance below this means "older".
  localparam logic [TAG_W-1:0] HALF = TAG_W'(1) << (TAG_W - 1);

  typedef struct packed {
    logic [4:0]       rd;
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } wb_entry_t;

  wb_entry_t        mem    [NP][FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr [NP];
  logic [PTR_W-1:0] rd_ptr [NP];
  logic [CNT_W-1:0] count  [NP];
  wb_entry_t        head   [NP];

  logic [NP-1:0] push, pop, head_valid, cand, drop, elig, grant;
  logic [1:0]    rr_ptr, rr_next, last_idx;
  logic          sel1_v, sel2_v;
  logic [1:0]    sel1_idx, sel2_idx;
  wb_entry_t     sel1_entry, sel2_entry;

  // a is older than b when b is 1..HALF-1 steps ahead of a (modulo 2^TAG_W).
  function automatic logic is_older(input logic [TAG_W-1:0] a,
                                    input logic [TAG_W-1:0] b);
    logic [TAG_W-1:0] diff;
    diff = b - a;
    return (diff != '0) && (diff < HALF);
  endfunction

  // Does head j win over head i for the same destination? Ties (equal tags,
  // or exactly half the tag space apart) go to the lower producer index so
  // exactly one head of any same-rd pair stays eligible.
  function automatic logic takes_priority(input logic [TAG_W-1:0] tj,
                                          input logic [TAG_W-1:0] ti,
                                          input int j, input int i);
    return is_older(tj, ti) || (!is_older(ti, tj) && (j < i));
  endfunction

  // FIFO status, handshake and head decode.
  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    req_ready  = '0;
    push       = '0;
    head_valid = '0;
    cand       = '0;
    drop       = '0;
    for (int i = 0; i < NP; i++) begin
      req_ready[i]  = (count[i] < CNT_W'(FIFO_DEPTH));
      push[i]       = req_valid[i] && req_ready[i];
      head_valid[i] = (count[i] != '0);
      head[i]       = mem[i][rd_ptr[i]];
      cand[i]       = head_valid[i] && (head[i].rd != 5'd0);
      drop[i]       = head_valid[i] && (head[i].rd == 5'd0);
    end
  end

  // A candidate is eligible unless another candidate with the same rd wins.
  always_comb begin
    elig = '0;
    for (int i = 0; i < NP; i++) begin
      elig[i] = cand[i];
      for (int j = 0; j < NP; j++) begin
        if (j != i && cand[j] && head[j].rd == head[i].rd &&
            takes_priority(head[j].tag, head[i].tag, j, i))
          elig[i] = 1'b0;
      end
    end
  end

  // Round-robin scan from rr_ptr: first eligible head to port 1, second to port 2.
  always_comb begin
    int idx;
    idx        = 0;
    sel1_v     = 1'b0;
    sel2_v     = 1'b0;
    sel1_idx   = 2'd0;
    sel2_idx   = 2'd0;
    sel1_entry = '0;
    sel2_entry = '0;
    for (int k = 0; k < NP; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NP) idx = idx - NP;
      if (elig[idx]) begin
        if (!sel1_v) begin
          sel1_v     = 1'b1;
          sel1_idx   = 2'(idx);
          sel1_entry = head[idx];
        end else if (!sel2_v) begin
          sel2_v     = 1'b1;
          sel2_idx   = 2'(idx);
          sel2_entry = head[idx];
        end
      end
    end
  end

  // Grants, pops (grants plus silent r0 drops) and the next round-robin start.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NP; i++)
      grant[i] = (sel1_v && sel1_idx == 2'(i)) || (sel2_v && sel2_idx == 2'(i));
    pop      = grant | drop;
    last_idx = sel2_v ? sel2_idx : sel1_idx;
    if (sel1_v)
      rr_next = (last_idx == 2'd2) ? 2'd0 : last_idx + 2'd1;
    else
      rr_next = rr_ptr;
  end

  // NOTE: entry storage carries no reset; the cleared counts make stale
  // contents unreachable, and leaving it unreset keeps it plain RAM.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NP; i++) begin
      if (push[i])
        mem[i][wr_ptr[i]] <= '{rd:   req_rd[5*i +: 5],
                               data: req_data[32*i +: 32],
                               tag:  req_tag[TAG_W*i +: TAG_W]};
    end
  end

  // FIFO pointers and occupancy.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NP; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        count[i] <= count[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
      end
    end
  end

  // Round-robin pointer and registered write ports. An unused port drops its
  // enable but keeps the last address/data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= 2'd0;
      we1      <= 1'b0;
      wr_addr1 <= '0;
      wr_data1 <= '0;
      we2      <= 1'b0;
      wr_addr2 <= '0;
      wr_data2 <= '0;
    end else begin
      rr_ptr <= rr_next;
      we1    <= sel1_v;
      we2    <= sel2_v;
      if (sel1_v) begin
        wr_addr1 <= sel1_entry.rd;
        wr_data1 <= sel1_entry.data;
      end
      if (sel2_v) begin
        wr_addr2 <= sel2_entry.rd;
        wr_data2 <= sel2_entry.data;
      end
    end
  end

  assign busy = (|head_valid) | we1 | we2;

`ifdef WB_STALL_CNT_EN
  // A cycle stalls when some real (non-r0) head is left waiting.
  logic stall_event;
  assign stall_event = |(cand & ~grant);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cnt <= '0;
    else if (stall_event && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed testbench for regfile_wb_arbiter. Inputs are driven on the falling
// edge and outputs sampled on the falling edge, half a cycle away from the
// rising edge the design uses. Each scenario task carries its own checks.
`timescale 1ns/1ps

module tb_regfile_wb_arbiter;

  localparam int TAG_W = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [2:0]         req_valid;
  logic [2:0]         req_ready;
  logic [14:0]        req_rd;
  logic [95:0]        req_data;
  logic [3*TAG_W-1:0] req_tag;
  logic               we1, we2, busy;
  logic [4:0]         wr_addr1, wr_addr2;
  logic [31:0]        wr_data1, wr_data2;
`ifdef WB_STALL_CNT_EN
  logic [15:0]        stall_cnt;
`endif

  int checks = 0;
  int passed = 0;

  regfile_wb_arbiter #(.FIFO_DEPTH(2), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_rd    (req_rd),
    .req_data  (req_data),
    .req_tag   (req_tag),
    .we1       (we1),
    .wr_addr1  (wr_addr1),
    .wr_data1  (wr_data1),
    .we2       (we2),
    .wr_addr2  (wr_addr2),
    .wr_data2  (wr_data2),
    .busy      (busy)
`ifdef WB_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_rd    = '0;
    req_data  = '0;
    req_tag   = '0;
  endtask

  task automatic drive(input int p, input logic [4:0] rd,
                       input logic [31:0] data, input logic [TAG_W-1:0] tag);
    req_valid[p]            = 1'b1;
    req_rd[5*p +: 5]        = rd;
    req_data[32*p +: 32]    = data;
    req_tag[TAG_W*p +: TAG_W] = tag;
  endtask

  task automatic do_reset();
    clear_reqs();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    clear_reqs();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({we1, we2} !== 2'b00) $display("FAIL reset_we: got %b, want 00", {we1, we2}); else passed++;
    checks++;
    if ({wr_addr1, wr_addr2} !== 10'd0) $display("FAIL reset_addr: got %h/%h, want 0/0", wr_addr1, wr_addr2); else passed++;
    checks++;
    if ({wr_data1, wr_data2} !== 64'd0) $display("FAIL reset_data: got %h/%h, want 0/0", wr_data1, wr_data2); else passed++;
    checks++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b, want 0", busy); else passed++;
`ifdef WB_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) $display("FAIL reset_stall_cnt: got %0d, want 0", stall_cnt); else passed++;
`endif
    rst = 1'b1;
    tick();
    checks++;
    if (req_ready !== 3'b111) $display("FAIL reset_ready: got %b, want 111", req_ready); else passed++;
  endtask

  // P0 rd3 and P1 rd4 in one cycle land on both ports two edges later.
  task automatic test_dual_write();
    do_reset();
    drive(0, 5'd3, 32'h11, 4'd0);
    drive(1, 5'd4, 32'h22, 4'd1);
    tick();
    clear_reqs();
    checks++;
    if (we1 !== 1'b0 || busy !== 1'b1) $display("FAIL dual_latency: we1=%b busy=%b, want 0/1", we1, busy); else passed++;
    tick();
    checks++;
    if (we1 !== 1'b1 || wr_addr1 !== 5'd3 || wr_data1 !== 32'h11)
      $display("FAIL dual_port1: got we=%b a=%0d d=%h, want 1/3/11", we1, wr_addr1, wr_data1); else passed++;
    checks++;
    if (we2 !== 1'b1 || wr_addr2 !== 5'd4 || wr_data2 !== 32'h22)
      $display("FAIL dual_port2: got we=%b a=%0d d=%h, want 1/4/22", we2, wr_addr2, wr_data2); else passed++;
    tick();
    checks++;
    if ({we1, we2, busy} !== 3'b000) $display("FAIL dual_idle: we1/we2/busy=%b, want 000", {we1, we2, busy}); else passed++;
    checks++;
    if (wr_addr1 !== 5'd3 || wr_data1 !== 32'h11) $display("FAIL dual_hold: got a=%0d d=%h, want 3/11", wr_addr1, wr_data1); else passed++;
    // Last grant was P1, so the scan now starts at P2: P2 takes port 1.
    drive(1, 5'd12, 32'h120, 4'd2);
    drive(2, 5'd13, 32'h130, 4'd3);
    tick();
    clear_reqs();
    tick();
    checks++;
    if (wr_addr1 !== 5'd13 || wr_addr2 !== 5'd12 || !we1 || !we2)
      $display("FAIL dual_rr_at_2: got p1=%0d p2=%0d, want 13/12", wr_addr1, wr_addr2); else passed++;
    tick();
  endtask

  // Three producers at once: P0/P1 first, P2 next cycle, pointer back to 0.
  task automatic test_three_producers();
    do_reset();
    drive(0, 5'd5, 32'h55, 4'd0);
    drive(1, 5'd6, 32'h66, 4'd1);
    drive(2, 5'd7, 32'h77, 4'd2);
    tick();
    clear_reqs();
    tick();
    checks++;
    if (!we1 || !we2 || wr_addr1 !== 5'd5 || wr_data1 !== 32'h55 || wr_addr2 !== 5'd6 || wr_data2 !== 32'h66)
      $display("FAIL three_first: got %0d:%h / %0d:%h, want 5:55 / 6:66", wr_addr1, wr_data1, wr_addr2, wr_data2); else passed++;
    tick();
    checks++;
    if (we1 !== 1'b1 || wr_addr1 !== 5'd7 || wr_data1 !== 32'h77)
      $display("FAIL three_second: got we=%b %0d:%h, want 1 7:77", we1, wr_addr1, wr_data1); else passed++;
    checks++;
    if (we2 !== 1'b0 || wr_addr2 !== 5'd6) $display("FAIL three_port2_idle: got we=%b a=%0d, want 0/6", we2, wr_addr2); else passed++;
    tick();
    checks++;
    if (busy !== 1'b0) $display("FAIL three_busy: got %b, want 0", busy); else passed++;
    // Pointer is back at 0: P1 is scanned before P2.
    drive(1, 5'd12, 32'hC1, 4'd4);
    drive(2, 5'd13, 32'hD2, 4'd5);
    tick();
    clear_reqs();
    tick();
    checks++;
    if (wr_addr1 !== 5'd12 || wr_addr2 !== 5'd13) $display("FAIL three_rr_at_0: got p1=%0d p2=%0d, want 12/13", wr_addr1, wr_addr2); else passed++;
    tick();
  endtask

  // Same destination: the older tag goes first, one write per cycle.
  task automatic test_same_rd_age();
    do_reset();
    drive(0, 5'd9, 32'h90, 4'd3);
    drive(2, 5'd9, 32'h92, 4'd2);
    tick();
    clear_reqs();
    tick();
    checks++;
    if (we1 !== 1'b1 || wr_addr1 !== 5'd9 || wr_data1 !== 32'h92 || we2 !== 1'b0)
      $display("FAIL age_first: got we=%b%b a=%0d d=%h, want 10 9 92", we1, we2, wr_addr1, wr_data1); else passed++;
    tick();
    checks++;
    if (we1 !== 1'b1 || wr_data1 !== 32'h90 || we2 !== 1'b0)
      $display("FAIL age_second: got we=%b%b d=%h, want 10 90", we1, we2, wr_data1); else passed++;
    tick();
    // Wrap: tag 15 is older than tag 0.
    drive(0, 5'd9, 32'hF0, 4'd15);
    drive(2, 5'd9, 32'h0A, 4'd0);
    tick();
    clear_reqs();
    tick();
    checks++;
    if (we1 !== 1'b1 || wr_data1 !== 32'hF0 || we2 !== 1'b0)
      $display("FAIL age_wrap_first: got we=%b%b d=%h, want 10 F0", we1, we2, wr_data1); else passed++;
    tick();
    checks++;
    if (we1 !== 1'b1 || wr_data1 !== 32'h0A || we2 !== 1'b0)
      $display("FAIL age_wrap_second: got we=%b%b d=%h, want 10 0A", we1, we2, wr_data1); else passed++;
    tick();
    // Equal tags: the lower producer index goes first.
    drive(1, 5'd9, 32'h91, 4'd5);
    drive(2, 5'd9, 32'h29, 4'd5);
    tick();
    clear_reqs();
    tick();
    checks++;
    if (we1 !== 1'b1 || wr_data1 !== 32'h91 || we2 !== 1'b0)
      $display("FAIL age_tie: got we=%b%b d=%h, want 10 91", we1, we2, wr_data1); else passed++;
    tick();
    tick();
  endtask

  // A write to r0 is swallowed without touching the ports.
  task automatic test_r0_drop();
    do_reset();
    drive(1, 5'd0, 32'hDEAD, 4'd0);
    tick();
    clear_reqs();
    checks++;
    if (req_ready[1] !== 1'b1 || busy !== 1'b1) $display("FAIL r0_enqueued: ready1=%b busy=%b, want 1/1", req_ready[1], busy); else passed++;
    tick();
    checks++;
    if ({we1, we2, busy} !== 3'b000) $display("FAIL r0_no_write: we1/we2/busy=%b, want 000", {we1, we2, busy}); else passed++;
    checks++;
    if (wr_addr1 !== 5'd0 || wr_data1 !== 32'd0) $display("FAIL r0_port_quiet: got a=%0d d=%h, want 0/0", wr_addr1, wr_data1); else passed++;
    tick();
    checks++;
    if ({we1, we2} !== 2'b00) $display("FAIL r0_later: we=%b, want 00", {we1, we2}); else passed++;
  endtask

  // P0 (rd10, tag 8) is blocked behind a stream of older rd10 results from P1:
  // its FIFO fills after two entries, and the port order follows age then FIFO order.
  task automatic test_backpressure();
    logic [31:0] seen[$];
    logic [31:0] expq[$];
    int  i0, i1;
    bit  f0, f1, dup, done;
    i0 = 0; i1 = 0; dup = 1'b0; done = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 80; cyc++) begin
      if (we1 && wr_addr1 == 5'd10) seen.push_back(wr_data1);
      if (we2 && wr_addr2 == 5'd10) seen.push_back(wr_data2);
      if (we1 && we2 && wr_addr1 == wr_addr2) dup = 1'b1;
      if (cyc == 1) begin
        checks++;
        if (req_ready[0] !== 1'b1) $display("FAIL bp_ready_one_entry: got %b, want 1", req_ready[0]); else passed++;
      end
      if (cyc == 2) begin
        checks++;
        if (req_ready[0] !== 1'b0) $display("FAIL bp_ready_full: got %b, want 0", req_ready[0]); else passed++;
      end
      if (cyc == 6) begin
        checks++;
        if (i0 != 2) $display("FAIL bp_accepted_in_6: got %0d, want 2", i0); else passed++;
      end
      if (i0 == 6 && i1 == 6 && seen.size() == 12) begin
        done = 1'b1;
        break;
      end
      clear_reqs();
      if (i0 < 6) drive(0, 5'd10, 32'hA0 + 32'(i0), 4'd8);
      if (i1 < 6) drive(1, 5'd10, 32'hB0 + 32'(i1), 4'(i1 + 1));
      f0 = req_valid[0] && req_ready[0];
      f1 = req_valid[1] && req_ready[1];
      tick();
      if (f0) i0++;
      if (f1) i1++;
    end
    clear_reqs();
    checks++;
    if (!done) $display("FAIL bp_timeout: accepted %0d/%0d, written %0d, want 6/6/12", i0, i1, seen.size()); else passed++;
    checks++;
    if (dup) $display("FAIL bp_same_addr_both_ports: got 1, want 0"); else passed++;
    for (int k = 0; k < 6; k++) expq.push_back(32'hB0 + 32'(k));
    for (int k = 0; k < 6; k++) expq.push_back(32'hA0 + 32'(k));
    for (int k = 0; k < 12; k++) begin
      checks++;
      if (k >= seen.size()) $display("FAIL bp_order[%0d]: got nothing, want %h", k, expq[k]);
      else if (seen[k] !== expq[k]) $display("FAIL bp_order[%0d]: got %h, want %h", k, seen[k], expq[k]);
      else passed++;
    end
    tick();
    tick();
    checks++;
    if (busy !== 1'b0) $display("FAIL bp_drained_busy: got %b, want 0", busy); else passed++;
  endtask

  // Reset in the middle of a backlog: outputs clear at once, nothing replays.
  task automatic test_reset_midstream();
    do_reset();
    drive(0, 5'd21, 32'h100, 4'd8);
    drive(1, 5'd21, 32'h101, 4'd9);
    drive(2, 5'd21, 32'h102, 4'd10);
    tick();
    drive(0, 5'd21, 32'h110, 4'd11);
    drive(1, 5'd21, 32'h111, 4'd12);
    drive(2, 5'd21, 32'h112, 4'd13);
    tick();
    clear_reqs();
    checks++;
    if (we1 !== 1'b1 || wr_data1 !== 32'h100 || busy !== 1'b1)
      $display("FAIL mid_pre: we1=%b d=%h busy=%b, want 1/100/1", we1, wr_data1, busy); else passed++;
`ifdef WB_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd1) $display("FAIL mid_stall_pre: got %0d, want 1", stall_cnt); else passed++;
`endif
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({we1, we2, busy} !== 3'b000) $display("FAIL mid_async_clear: we1/we2/busy=%b, want 000", {we1, we2, busy}); else passed++;
    checks++;
    if ({wr_addr1, wr_addr2} !== 10'd0 || {wr_data1, wr_data2} !== 64'd0)
      $display("FAIL mid_async_ports: got %0d:%h %0d:%h, want zeros", wr_addr1, wr_data1, wr_addr2, wr_data2); else passed++;
`ifdef WB_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 16'd0) $display("FAIL mid_stall_clear: got %0d, want 0", stall_cnt); else passed++;
`endif
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++;
      if ({we1, we2, busy} !== 3'b000) $display("FAIL mid_no_replay[%0d]: we1/we2/busy=%b, want 000", c, {we1, we2, busy}); else passed++;
    end
    checks++;
    if (req_ready !== 3'b111) $display("FAIL mid_ready: got %b, want 111", req_ready); else passed++;
  endtask

  initial begin
    clear_reqs();
    test_reset();
    test_dual_write();
    test_three_producers();
    test_same_rd_age();
    test_r0_drop();
    test_backpressure();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
